del_meas_engine: RTL
====================

// Module: del_meas_engine
// PURPOSE
//  Parametrised multi-shot probe-delay measurement engine; calibrates DAC->ADC latency per ADC channel.
//  Fires a probe pulse on one selected DAC channel and times arrival on every ADC channel by threshold crossing.
//  Repeats for N shots and reports per-channel accumulated delay plus timeout flags.
//  Sits between the control registers and the DAC/ADC drivers; DAC muxing lives outside this block.
// PARAMETERS
//  NUM_BITS  16   sample width, two's complement
//  NUM_DAC   3    DAC channels driven (alpha, beta, gamma)
//  NUM_ADC   2    ADC channels timed (MAC, NL)
//  CNT_W     16   per-shot delay counter width
//  TIMEOUT   255  max wait cycles per shot before a channel times out
//  GAP_CYC   32   settle cycles between shots, DACs held at 0
//  SUM_W     CNT_W+8  accumulator width (covers 255 shots)
// PORTS
//  clk          in   1                 system clock
//  rst          in   1                 async active-low reset
//  start        in   1                 level; rising use starts a run from IDLE
//  abort        in   1                 sync abort, any state
//  dac_sel      in   $clog2(NUM_DAC)   DAC channel carrying the probe
//  probe_val    in   NUM_BITS          probe amplitude
//  thresh       in   NUM_BITS          arrival threshold (unsigned magnitude)
//  num_shots    in   8                 shots per run; 0 treated as 1
//  dac_out      out  NUM_DAC*NUM_BITS  DAC samples, channel i at [i*NUM_BITS +: NUM_BITS]
//  dac_valid    out  NUM_DAC           DAC sample valid
//  adc_in       in   NUM_ADC*NUM_BITS  ADC samples, same packing
//  adc_valid    in   NUM_ADC           ADC sample valid
//  adc_run      out  1                 high while ADC capture needed (PULSE..GAP)
//  busy         out  1                 high in any state except IDLE
//  done         out  1                 run finished, results stable
//  result       out  NUM_ADC*SUM_W     summed delay per channel; all ones if channel ever timed out
//  timeout_flg  out  NUM_ADC           sticky per-channel timeout for this run
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; counters, accumulators, latched config 0.
//  States: IDLE, PULSE, WAIT, GAP, DONE.
//  IDLE: start=1 -> latch dac_sel/probe_val/thresh/num_shots; clear result, timeout_flg, shot count; -> PULSE.
//  PULSE (1 cycle): dac_out[sel]=probe_val, other channels 0, dac_valid all 1, adc_run=1; clear per-shot
//   arrived bits and set per-shot counter to 1; -> WAIT.
//  WAIT: dac_out all 0, dac_valid all 1. Each cycle, channel i arrives when adc_valid[i] and |adc_in[i]| > thresh
//   and not yet arrived; its delay = current counter value (first WAIT cycle = 1) is added to its accumulator.
//   Counter increments each WAIT cycle. When counter == TIMEOUT, unarrived channels set timeout_flg.
//   Exit to GAP when every channel has arrived or timed out; arrival on the TIMEOUT cycle counts as arrival.
//  Magnitude: two's complement abs; most-negative value saturates to max positive; compare unsigned, strict >.
//  GAP: DACs 0 and valid, GAP_CYC cycles; then shot count+1; if count == max(num_shots,1) -> DONE, else PULSE.
//  DONE: done=1; result[i] = accumulator, or all ones if timeout_flg[i]; stay until start=0 -> IDLE
//   (done cleared on leaving). start held high does not retrigger.
//  abort=1 in any state: -> IDLE next cycle; dac_valid, adc_run, done, busy 0; results and flags cleared.
//   abort has priority over start and all transitions.
//  start changes and config changes mid-run are ignored (config latched in IDLE).
//  Accumulator never wraps: SUM_W covers 255*TIMEOUT; saturate anyway if TIMEOUT is overridden larger.
//  adc_valid low on a cycle: no arrival that cycle, counter still advances.
// STRUCTURE
//  Package del_meas_pkg: state enum type, abs_sat function, shared field-width localparams.
//  Sub-module del_meas_chan (one per ADC via generate): magnitude, threshold compare, arrived/timeout
//   latch, delay accumulator; top holds FSM, counters, DAC output mux.
// TESTING
//  1. NUM_ADC=2, thresh=100, num_shots=1; ADC0 exceeds on WAIT cycle 5, ADC1 on 9 -> result {9,5}, flags 0, done.
//  2. num_shots=4, ADC0 arrives at 7,7,8,6 -> result[0]=28; PULSE seen exactly 4 times, GAP_CYC cycles between.
//  3. ADC1 never crosses, TIMEOUT=255 -> WAIT lasts 255 cycles; timeout_flg=2'b10, result[1]=all ones.
//  4. adc_in=16'h8000 with thresh=16'h7FFE -> arrival (abs saturates to 7FFF); thresh=7FFF -> no arrival.
//  5. abort asserted mid-WAIT of shot 2 -> IDLE next cycle, all outputs 0; new start runs cleanly.
//  6. rst low mid-GAP -> all outputs 0 immediately; start held high after DONE -> no second run until start toggles.

Source files
------------

// File: rtl/del_meas_pkg.sv
// del_meas_pkg: shared state type, field widths and saturating magnitude for the delay engine
package del_meas_pkg;
    localparam int SHOT_W = 8;
    localparam int ABS_W  = 32;

    typedef enum logic [2:0] {S_IDLE, S_PULSE, S_WAIT, S_GAP, S_DONE} state_t;

    // |v| of a sign-extended w-bit sample, clamped to the largest positive w-bit value
    function automatic logic [ABS_W-1:0] abs_sat(input logic [ABS_W-1:0] v, input int w);
        logic [ABS_W-1:0] mag;
        logic [ABS_W-1:0] lim;
        mag = v[ABS_W-1] ? ~v + 1'b1 : v;
        lim = (ABS_W'(1) << (w - 1)) - 1'b1;
        return (mag > lim) ? lim : mag;
    endfunction
endpackage

// File: rtl/del_meas_chan.sv
// del_meas_chan: per-ADC arrival detection, sticky timeout and saturating delay accumulator
module del_meas_chan
    import del_meas_pkg::*;
#(
    parameter int NUM_BITS = 16,
    parameter int CNT_W    = 16,
    parameter int SUM_W    = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                shot_clr,
    input  logic                in_wait,
    input  logic                at_timeout,
    input  logic [CNT_W-1:0]    cnt,
    input  logic [NUM_BITS-1:0] sample,
    input  logic [NUM_BITS-1:0] thresh,
    input  logic                valid,
    output logic                shot_done,
    output logic                tflag,
    output logic [SUM_W-1:0]    acc
);
    logic             arrived;
    logic             hit;
    logic [ABS_W-1:0] mag;
    logic [SUM_W:0]   sum;

    // first threshold crossing of this shot and the accumulator's next value
    always_comb begin
        mag       = abs_sat(ABS_W'($signed(sample)), NUM_BITS);
        hit       = in_wait && valid && !arrived && (mag > ABS_W'(thresh));
        sum       = {1'b0, acc} + (SUM_W+1)'(cnt);
        shot_done = arrived || hit;
    end

    // arrival latch per shot, timeout flag and accumulator sticky per run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arrived <= 1'b0;
            tflag   <= 1'b0;
            acc     <= '0;
        end else if (clr) begin
            arrived <= 1'b0;
            tflag   <= 1'b0;
            acc     <= '0;
        end else begin
            if (shot_clr)
                arrived <= 1'b0;
            else if (hit)
                arrived <= 1'b1;
            if (hit)
                acc <= sum[SUM_W] ? '1 : sum[SUM_W-1:0];
            if (in_wait && at_timeout && !shot_done)
                tflag <= 1'b1;
        end
    end
endmodule

// File: rtl/del_meas_engine.sv
// del_meas_engine: multi-shot DAC->ADC probe delay measurement with per-channel timeout
module del_meas_engine
    import del_meas_pkg::*;
#(
    parameter int NUM_BITS = 16,
    parameter int NUM_DAC  = 3,
    parameter int NUM_ADC  = 2,
    parameter int CNT_W    = 16,
    parameter int TIMEOUT  = 255,
    parameter int GAP_CYC  = 32,
    parameter int SUM_W    = CNT_W + 8,
    localparam int SEL_W   = NUM_DAC > 1 ? $clog2(NUM_DAC) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic [SEL_W-1:0]            dac_sel,
    input  logic [NUM_BITS-1:0]         probe_val,
    input  logic [NUM_BITS-1:0]         thresh,
    input  logic [SHOT_W-1:0]           num_shots,
    output logic [NUM_DAC*NUM_BITS-1:0] dac_out,
    output logic [NUM_DAC-1:0]          dac_valid,
    input  logic [NUM_ADC*NUM_BITS-1:0] adc_in,
    input  logic [NUM_ADC-1:0]          adc_valid,
    output logic                        adc_run,
    output logic                        busy,
    output logic                        done,
    output logic [NUM_ADC*SUM_W-1:0]    result,
    output logic [NUM_ADC-1:0]          timeout_flg
);
    state_t                      state;
    logic [SEL_W-1:0]            sel_r;
    logic [NUM_BITS-1:0]         probe_r;
    logic [NUM_BITS-1:0]         thresh_r;
    logic [SHOT_W-1:0]           shots_r;
    logic [SHOT_W-1:0]           shot_cnt;
    logic [CNT_W-1:0]            cnt;
    logic [NUM_ADC-1:0]          ch_done;
    logic [NUM_ADC*SUM_W-1:0]    acc_flat;
    logic [NUM_ADC*SUM_W-1:0]    res_c;
    logic [NUM_DAC*NUM_BITS-1:0] pulse_vec;
    logic [SEL_W-1:0]            psel;
    logic [NUM_BITS-1:0]         pval;
    logic                        in_wait;
    logic                        at_timeout;
    logic                        shot_clr;
    logic                        clr;
    logic                        last_shot;

    // pulse pattern (live config in IDLE, latched afterwards), final results and FSM decodes
    always_comb begin
        psel       = (state == S_IDLE) ? dac_sel : sel_r;
        pval       = (state == S_IDLE) ? probe_val : probe_r;
        pulse_vec  = '0;
        res_c      = '0;
        for (int n = 0; n < NUM_DAC; n++)
            pulse_vec[n*NUM_BITS +: NUM_BITS] = (psel == SEL_W'(n)) ? pval : '0;
        for (int n = 0; n < NUM_ADC; n++)
            res_c[n*SUM_W +: SUM_W] = timeout_flg[n] ? '1 : acc_flat[n*SUM_W +: SUM_W];
        in_wait    = state == S_WAIT;
        at_timeout = cnt == CNT_W'(TIMEOUT);
        shot_clr   = state == S_PULSE;
        clr        = abort || (state == S_IDLE && start);
        last_shot  = (shot_cnt + 1'b1) == ((shots_r == '0) ? SHOT_W'(1) : shots_r);
    end

    for (genvar i = 0; i < NUM_ADC; i++) begin : g_chan
        del_meas_chan #(.NUM_BITS(NUM_BITS), .CNT_W(CNT_W), .SUM_W(SUM_W)) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr       (clr),
            .shot_clr  (shot_clr),
            .in_wait   (in_wait),
            .at_timeout(at_timeout),
            .cnt       (cnt),
            .sample    (adc_in[i*NUM_BITS +: NUM_BITS]),
            .thresh    (thresh_r),
            .valid     (adc_valid[i]),
            .shot_done (ch_done[i]),
            .tflag     (timeout_flg[i]),
            .acc       (acc_flat[i*SUM_W +: SUM_W])
        );
    end

    // run sequencer; outputs are set on the transition into the state they belong to
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            sel_r     <= '0;
            probe_r   <= '0;
            thresh_r  <= '0;
            shots_r   <= '0;
            shot_cnt  <= '0;
            cnt       <= '0;
            dac_out   <= '0;
            dac_valid <= '0;
            adc_run   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
        end else if (abort) begin
            state     <= S_IDLE;
            shot_cnt  <= '0;
            cnt       <= '0;
            dac_out   <= '0;
            dac_valid <= '0;
            adc_run   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    state     <= S_PULSE;
                    sel_r     <= dac_sel;
                    probe_r   <= probe_val;
                    thresh_r  <= thresh;
                    shots_r   <= num_shots;
                    shot_cnt  <= '0;
                    result    <= '0;
                    dac_out   <= pulse_vec;
                    dac_valid <= '1;
                    adc_run   <= 1'b1;
                    busy      <= 1'b1;
                end
                S_PULSE: begin
                    state   <= S_WAIT;
                    cnt     <= CNT_W'(1);
                    dac_out <= '0;
                end
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (&ch_done || at_timeout) begin
                        state <= S_GAP;
                        cnt   <= CNT_W'(1);
                    end
                end
                S_GAP: if (cnt == CNT_W'(GAP_CYC)) begin
                    shot_cnt <= shot_cnt + 1'b1;
                    if (last_shot) begin
                        state     <= S_DONE;
                        dac_valid <= '0;
                        adc_run   <= 1'b0;
                        done      <= 1'b1;
                        result    <= res_c;
                    end else begin
                        state   <= S_PULSE;
                        dac_out <= pulse_vec;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
                S_DONE: if (!start) begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
